// File: rtl/md_sched.sv
// md_sched
//   Multi-cycle multiply/divide scheduler for the execute stage. One
//   mult/multu/div/divu/mthi/mtlo operation is accepted per start pulse.
//   Multiply and divide results are computed and latched at the start edge,
//   the unit then reports busy for a fixed latency, and the 64-bit result is
//   committed into the architectural HI/LO registers at the end of that
//   window. mthi/mtlo write HI/LO directly with no busy time.
//
// Ports
//   clk      in   1   system clock, rising-edge
//   rst_n    in   1   asynchronous active-low reset
//   md_start in   1   one-cycle operation request from EXE
//   md_op    in   3   000 mult, 001 multu, 010 div, 011 divu,
//                     100 mthi, 101 mtlo, 110/111 no-op
//   md_a     in  32   operand A (rs)
//   md_b     in  32   operand B (rt)
//   md_busy  out  1   high while a result is pending
//   md_hi    out 32   architectural HI
//   md_lo    out 32   architectural LO
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  logic is_mul, is_div, is_mthi, is_mtlo;
  logic accept;

  logic signed [63:0] sext_a, sext_b, prod_s;
  logic [63:0] prod_u;

  logic        a_neg, b_neg, b_zero;
  logic [31:0] abs_a, abs_b, safe_abs_b, safe_b;
  logic [31:0] sq_mag, sr_mag, s_quot, s_rem;
  logic [31:0] u_quot, u_rem;
  logic [31:0] div_hi, div_lo;

  // Decode the operation class once so the FSM below reads cleanly.
  always_comb begin
    is_mul  = (md_op == 3'b000) || (md_op == 3'b001);
    is_div  = (md_op == 3'b010) || (md_op == 3'b011);
    is_mthi = (md_op == 3'b100);
    is_mtlo = (md_op == 3'b101);
  end

  // Both products are formed every cycle; only the one selected by md_op is
  // latched. Sign-extending to 64 bits makes the truncated signed product
  // exact.
  always_comb begin
    sext_a = {{32{md_a[31]}}, md_a};
    sext_b = {{32{md_b[31]}}, md_b};
    prod_s = sext_a * sext_b;
    prod_u = {32'd0, md_a} * {32'd0, md_b};
  end

  // Signed division is done on magnitudes and then re-signed: the quotient
  // takes the XOR of the operand signs and the remainder follows the
  // dividend. This form also yields 0x80000000 rem 0 for the
  // 0x80000000 / -1 overflow case without a special case. A zero divisor is
  // replaced by 1 so the dividers never see zero; its result is overridden.
  always_comb begin
    a_neg      = md_a[31];
    b_neg      = md_b[31];
    b_zero     = (md_b == 32'd0);
    abs_a      = a_neg ? (32'd0 - md_a) : md_a;
    abs_b      = b_neg ? (32'd0 - md_b) : md_b;
    safe_abs_b = b_zero ? 32'd1 : abs_b;
    safe_b     = b_zero ? 32'd1 : md_b;
    sq_mag     = abs_a / safe_abs_b;
    sr_mag     = abs_a % safe_abs_b;
    s_quot     = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
    s_rem      = a_neg ? (32'd0 - sr_mag) : sr_mag;
    u_quot     = md_a / safe_b;
    u_rem      = md_a % safe_b;
    if (b_zero) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = md_a;
    end else if (md_op[0]) begin
      div_lo = u_quot;
      div_hi = u_rem;
    end else begin
      div_lo = s_quot;
      div_hi = s_rem;
    end
  end

  // Next-state logic. A start is honoured in IDLE, or on the final RUN
  // cycle so back-to-back operations commit and relaunch on the same edge.
  // The commit is applied first so a same-edge mthi/mtlo lands on top of it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    accept   = md_start && ((state_q == IDLE) || (cnt_q == 4'd1));

    if (state_q == RUN) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d    = res_hi_q;
        lo_d    = res_lo_q;
        state_d = IDLE;
      end
    end

    if (accept) begin
      if (is_mul) begin
        res_hi_d = md_op[0] ? prod_u[63:32] : prod_s[63:32];
        res_lo_d = md_op[0] ? prod_u[31:0]  : prod_s[31:0];
        cnt_d    = MULT_CNT;
        state_d  = RUN;
      end else if (is_div) begin
        res_hi_d = div_hi;
        res_lo_d = div_lo;
        cnt_d    = DIV_CNT;
        state_d  = RUN;
      end else if (is_mthi) begin
        hi_d = md_a;
      end else if (is_mtlo) begin
        lo_d = md_a;
      end
    end
  end

  // State register. Reset discards any pending result and clears HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign md_busy = (state_q == RUN);
  assign md_hi   = hi_q;
  assign md_lo   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched
//   Scoreboard bench for md_sched. The driver applies one input set per
//   cycle, advances a cycle-indexed reference model and queues the expected
//   post-edge {busy, HI, LO}; a monitor pops and compares after every edge.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        rst_n;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  typedef struct {
    int          edge_no;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: architectural HI/LO, a pending result and the
  // edge index at which it becomes architectural.
  int          edge_k  = 0;
  int          free_at = 0;
  bit          pending = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_pend = 0;

  md_sched #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .md_start(md_start),
    .md_op   (md_op),
    .md_a    (md_a),
    .md_b    (md_b),
    .md_busy (md_busy),
    .md_hi   (md_hi),
    .md_lo   (md_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {HI, LO} straight from the arithmetic definitions using 64-bit
  // integer arithmetic.
  function automatic logic [63:0] refResult(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    logic [63:0] res;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = 64'd0;
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (op == 3'd2) begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.edge_no = edge_k;
    e.busy    = (edge_k < free_at);
    e.hi      = m_hi;
    e.lo      = m_lo;
    exp_q.push_back(e);
    edge_k++;
  endtask

  // One clock of stimulus with reset released. Operands not part of an
  // accepted start are still randomised to show they are ignored.
  task automatic applyStimulus(input logic start, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst_n    = 1'b1;
    md_start = start;
    md_op    = op;
    md_a     = a;
    md_b     = b;
    if (pending && edge_k == free_at) begin
      m_hi    = m_pend[63:32];
      m_lo    = m_pend[31:0];
      pending = 0;
    end
    if (start && edge_k >= free_at) begin
      case (op)
        3'd0, 3'd1: begin
          m_pend  = refResult(op, a, b);
          pending = 1;
          free_at = edge_k + MULT_N;
        end
        3'd2, 3'd3: begin
          m_pend  = refResult(op, a, b);
          pending = 1;
          free_at = edge_k + DIV_N;
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
    pushExpected();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  // Holds reset for n edges with random inputs; the outputs must clear
  // immediately, without waiting for a clock edge.
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n    = 1'b0;
      md_start = 1'($urandom);
      md_op    = 3'($urandom);
      md_a     = $urandom;
      md_b     = $urandom;
      if (i == 0) begin
        #1;
        checkOutput("reset_async_busy", {31'd0, md_busy}, 32'd0);
        checkOutput("reset_async_hi", md_hi, 32'd0);
        checkOutput("reset_async_lo", md_lo, 32'd0);
      end
      m_hi    = 0;
      m_lo    = 0;
      pending = 0;
      free_at = 0;
      pushExpected();
    end
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: after each rising edge compare the DUT against the queued
  // expectation for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("e%0d_busy", e.edge_no), {31'd0, md_busy},
                    {31'd0, e.busy});
        checkOutput($sformatf("e%0d_hi", e.edge_no), md_hi, e.hi);
        checkOutput($sformatf("e%0d_lo", e.edge_no), md_lo, e.lo);
      end
    end
  end

  // Watchdog so the run always reaches its summary line.
  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [2:0]  op;
    logic        st;
    rst_n    = 1'b0;
    md_start = 1'b0;
    md_op    = 3'd0;
    md_a     = 32'd0;
    md_b     = 32'd0;

    doReset(4);
    idle(2);

    // mult / multu of -1 and 2
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    idle(MULT_N + 1);
    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    idle(MULT_N + 1);

    // div -7/2, divu 7/0
    applyStimulus(1'b1, 3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    idle(DIV_N + 1);
    applyStimulus(1'b1, 3'd3, 32'h0000_0007, 32'h0000_0000);
    idle(DIV_N + 1);

    // overflow divide with an ignored mtlo in the middle of RUN
    applyStimulus(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(2);
    applyStimulus(1'b1, 3'd5, 32'h0000_1234, $urandom);
    idle(DIV_N);

    // mthi then back-to-back multiplies
    applyStimulus(1'b1, 3'd4, 32'hDEAD_BEEF, $urandom);
    applyStimulus(1'b1, 3'd0, 32'h0000_0003, 32'hFFFF_FFFB);
    idle(MULT_N - 1);
    applyStimulus(1'b1, 3'd1, 32'h1234_5678, 32'h0000_0009);
    idle(MULT_N + 1);

    // reset in the middle of a multiply
    applyStimulus(1'b1, 3'd0, 32'h0000_0003, 32'h0000_0004);
    idle(1);
    doReset(2);
    idle(MULT_N + 4);

    // random traffic, including protocol-violating starts during RUN
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 2) == 0);
      op = 3'($urandom_range(0, 7));
      if (st && pending && edge_k == free_at && (op == 3'd4 || op == 3'd5))
        op = 3'd6;
      applyStimulus(st, op, randOperand(), randOperand());
    end
    idle(DIV_N + 2);

    @(negedge clk);
    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
